// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared funct3 codes, MEM-stage FSM states, byte-enable type and access-size helpers.
package mem_stage_pkg;
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;
    typedef logic [3:0] be_t;

    // Any funct3 that is not byte or half falls back to a word access.
    function automatic logic is_byte(input logic [2:0] f3);
        return (f3 == F3_LB) || (f3 == F3_LBU);
    endfunction

    function automatic logic is_half(input logic [2:0] f3);
        return (f3 == F3_LH) || (f3 == F3_LHU);
    endfunction

    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
        return (is_half(f3) & a[0]) | (!is_byte(f3) & !is_half(f3) & (|a));
    endfunction
endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational lane steering for data-memory accesses.
//   i_lane       address bits [1:0]
//   i_funct3     access size/sign
//   i_store_data rs2 value, replicated across lanes on o_wdata
//   i_rdata      raw memory word, extracted/extended onto o_load_data
//   o_be         byte enables for the access
module lsu_align
    import mem_stage_pkg::*;
(
    input  logic [1:0]  i_lane,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_store_data,
    input  logic [31:0] i_rdata,
    output be_t         o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_load_data
);
    logic        w_byte;
    logic        w_half;
    logic        w_signed;
    logic [1:0]  w_off;
    logic [31:0] w_shifted;

    always_comb begin
        w_byte      = is_byte(i_funct3);
        w_half      = is_half(i_funct3);
        w_signed    = (i_funct3 == F3_LB) || (i_funct3 == F3_LH);
        // Halves ignore a[0] and words ignore a[1:0]: misaligned accesses are truncated.
        w_off       = w_byte ? i_lane : w_half ? {i_lane[1], 1'b0} : 2'b00;
        o_be        = w_byte ? be_t'(4'b0001 << w_off) : w_half ? be_t'(4'b0011 << w_off) : 4'b1111;
        o_wdata     = w_byte ? {4{i_store_data[7:0]}} : w_half ? {2{i_store_data[15:0]}} : i_store_data;
        w_shifted   = i_rdata >> {w_off, 3'b000};
        o_load_data = w_byte ? {{24{w_signed & w_shifted[7]}}, w_shifted[7:0]}
                    : w_half ? {{16{w_signed & w_shifted[15]}}, w_shifted[15:0]}
                    : i_rdata;
    end
endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: RISC-V MEM stage with ready-handshaked data memory and MEM/WB register.
//   EX/MEM in : in_valid_i, alu_result_i, store_data_i, mem_read_i, mem_write_i, funct3_i, reg_write_i, rd_i
//   stall_o   : holds EX/MEM and earlier stages while a memory access is pending
//   dmem_*    : request/we/word address/byte enables/write data out, ready/rdata in
//   wb_*      : registered MEM/WB slot
//   misalign_o: present only when MEM_MISALIGN_TRAP_EN is defined
module mem_access_stage
    import mem_stage_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int RF_ADDR_W = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid_i,
    input  logic [31:0]          alu_result_i,
    input  logic [31:0]          store_data_i,
    input  logic                 mem_read_i,
    input  logic                 mem_write_i,
    input  logic [2:0]           funct3_i,
    input  logic                 reg_write_i,
    input  logic [RF_ADDR_W-1:0] rd_i,
    output logic                 stall_o,
    output logic                 dmem_req_o,
    output logic                 dmem_we_o,
    output logic [ADDR_W-1:0]    dmem_addr_o,
    output logic [3:0]           dmem_be_o,
    output logic [31:0]          dmem_wdata_o,
    input  logic                 dmem_ready_i,
    input  logic [31:0]          dmem_rdata_i,
    output logic                 wb_valid_o,
    output logic [31:0]          wb_data_o,
    output logic                 wb_reg_write_o,
`ifdef MEM_MISALIGN_TRAP_EN
    output logic                 misalign_o,
`endif
    output logic [RF_ADDR_W-1:0] wb_rd_o
);
    state_t               r_state;
    logic [ADDR_W-1:0]    r_addr;
    logic [1:0]           r_lane;
    logic [2:0]           r_funct3;
    logic                 r_we;
    be_t                  r_be;
    logic [31:0]          r_wdata;
    logic                 r_reg_write;
    logic [RF_ADDR_W-1:0] r_rd;
    logic                 r_wb_valid;
    logic [31:0]          r_wb_data;
    logic                 r_wb_reg_write;
    logic [RF_ADDR_W-1:0] r_wb_rd;
`ifdef MEM_MISALIGN_TRAP_EN
    logic                 r_misalign;
`endif
    logic                 w_misalign;
    logic                 w_mem_op;
    logic [1:0]           w_lane;
    logic [2:0]           w_funct3;
    be_t                  w_be;
    logic [31:0]          w_wdata;
    logic [31:0]          w_load_data;

    always_comb begin
`ifdef MEM_MISALIGN_TRAP_EN
        w_misalign = in_valid_i & (mem_read_i | mem_write_i) & is_misaligned(funct3_i, alu_result_i[1:0]);
`else
        w_misalign = 1'b0;
`endif
        w_mem_op = in_valid_i & (mem_read_i | mem_write_i) & !w_misalign;
        // The aligner serves the incoming op in IDLE and the latched op in ACCESS.
        w_lane   = (r_state == ACCESS) ? r_lane : alu_result_i[1:0];
        w_funct3 = (r_state == ACCESS) ? r_funct3 : funct3_i;
        stall_o  = (r_state == ACCESS) ? !dmem_ready_i : w_mem_op;
    end

    lsu_align u_align (
        .i_lane       (w_lane),
        .i_funct3     (w_funct3),
        .i_store_data (store_data_i),
        .i_rdata      (dmem_rdata_i),
        .o_be         (w_be),
        .o_wdata      (w_wdata),
        .o_load_data  (w_load_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state        <= IDLE;
            r_addr         <= '0;
            r_lane         <= '0;
            r_funct3       <= '0;
            r_we           <= 1'b0;
            r_be           <= '0;
            r_wdata        <= '0;
            r_reg_write    <= 1'b0;
            r_rd           <= '0;
            r_wb_valid     <= 1'b0;
            r_wb_data      <= '0;
            r_wb_reg_write <= 1'b0;
            r_wb_rd        <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
            r_misalign     <= 1'b0;
`endif
        end else if (r_state == IDLE) begin
`ifdef MEM_MISALIGN_TRAP_EN
            r_misalign <= w_misalign;
`endif
            if (w_mem_op) begin
                r_state        <= ACCESS;
                r_addr         <= {alu_result_i[ADDR_W-1:2], 2'b00};
                r_lane         <= alu_result_i[1:0];
                r_funct3       <= funct3_i;
                // A simultaneous read and write is treated as a load.
                r_we           <= mem_write_i & !mem_read_i;
                r_be           <= w_be;
                r_wdata        <= w_wdata;
                r_reg_write    <= reg_write_i;
                r_rd           <= rd_i;
                r_wb_valid     <= 1'b0;
                r_wb_reg_write <= 1'b0;
            end else begin
                r_wb_valid     <= in_valid_i;
                r_wb_data      <= alu_result_i;
                r_wb_rd        <= rd_i;
                r_wb_reg_write <= in_valid_i & reg_write_i & (rd_i != '0) & !w_misalign;
            end
        end else if (dmem_ready_i) begin
            r_state        <= IDLE;
            r_wb_valid     <= 1'b1;
            r_wb_data      <= w_load_data;
            r_wb_rd        <= r_rd;
            r_wb_reg_write <= !r_we & r_reg_write & (r_rd != '0);
        end
    end

    assign dmem_req_o     = (r_state == ACCESS);
    assign dmem_we_o      = r_we;
    assign dmem_addr_o    = r_addr;
    assign dmem_be_o      = r_be;
    assign dmem_wdata_o   = r_wdata;
    assign wb_valid_o     = r_wb_valid;
    assign wb_data_o      = r_wb_data;
    assign wb_reg_write_o = r_wb_reg_write;
    assign wb_rd_o        = r_wb_rd;
`ifdef MEM_MISALIGN_TRAP_EN
    assign misalign_o     = r_misalign;
`endif
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed self-checking bench with a queue-based write-back model.
module tb_mem_access_stage;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid_i;
    logic [31:0] alu_result_i;
    logic [31:0] store_data_i;
    logic        mem_read_i;
    logic        mem_write_i;
    logic [2:0]  funct3_i;
    logic        reg_write_i;
    logic [4:0]  rd_i;
    logic        stall_o;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [3:0]  dmem_be_o;
    logic [31:0] dmem_wdata_o;
    logic        dmem_ready_i;
    logic [31:0] dmem_rdata_i;
    logic        wb_valid_o;
    logic [31:0] wb_data_o;
    logic        wb_reg_write_o;
    logic [4:0]  wb_rd_o;
`ifdef MEM_MISALIGN_TRAP_EN
    logic        misalign_o;
`endif

    mem_access_stage dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid_i     (in_valid_i),
        .alu_result_i   (alu_result_i),
        .store_data_i   (store_data_i),
        .mem_read_i     (mem_read_i),
        .mem_write_i    (mem_write_i),
        .funct3_i       (funct3_i),
        .reg_write_i    (reg_write_i),
        .rd_i           (rd_i),
        .stall_o        (stall_o),
        .dmem_req_o     (dmem_req_o),
        .dmem_we_o      (dmem_we_o),
        .dmem_addr_o    (dmem_addr_o),
        .dmem_be_o      (dmem_be_o),
        .dmem_wdata_o   (dmem_wdata_o),
        .dmem_ready_i   (dmem_ready_i),
        .dmem_rdata_i   (dmem_rdata_i),
        .wb_valid_o     (wb_valid_o),
        .wb_data_o      (wb_data_o),
        .wb_reg_write_o (wb_reg_write_o),
`ifdef MEM_MISALIGN_TRAP_EN
        .misalign_o     (misalign_o),
`endif
        .wb_rd_o        (wb_rd_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic        rw;
        logic [4:0]  rd;
        logic        cd;
        logic        mis;
    } exp_t;

    exp_t        q[$];
    exp_t        ce;
    int          checks = 0;
    int          errors = 0;
    int          cap_stall;
    logic [31:0] cap_addr;
    logic [3:0]  cap_be;
    logic [31:0] cap_wdata;
    logic        cap_we;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", n, act, exp);
        end
    endtask

    function automatic int size_of(input logic [2:0] f3);
        return (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
        int off = int'(a % 4);
        int sz = size_of(f3);
        return sz == 1 ? 4'(1 << off) : sz == 2 ? 4'(3 << (off / 2 * 2)) : 4'hF;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] sd);
        int sz = size_of(f3);
        return sz == 1 ? {24'd0, sd[7:0]} * 32'h0101_0101 : sz == 2 ? {16'd0, sd[15:0]} * 32'h0001_0001 : sd;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rdata);
        int sz = size_of(f3);
        int off = (sz == 4) ? 0 : int'(a % 4) / sz * sz;
        logic [31:0] v = rdata >> (8 * off);
        if (sz == 1) begin
            v = v & 32'hFF;
            if (f3 < 3'd4 && v >= 32'h80) v = v | 32'hFFFF_FF00;
        end else if (sz == 2) begin
            v = v & 32'hFFFF;
            if (f3 < 3'd4 && v >= 32'h8000) v = v | 32'hFFFF_0000;
        end
        return v;
    endfunction

    function automatic logic m_mis(input logic [2:0] f3, input logic [31:0] a);
`ifdef MEM_MISALIGN_TRAP_EN
        return (size_of(f3) == 2 && a % 2 != 0) || (size_of(f3) == 4 && a % 4 != 0);
`else
        return 1'b0;
`endif
    endfunction

    // One instruction through the stage; memory answers on the lat-th ACCESS cycle.
    task automatic op(input logic v, input logic [31:0] a, input logic [31:0] sd, input logic mr, input logic mw,
                      input logic [2:0] f3, input logic rw, input logic [4:0] rd, input int lat, input logic [31:0] rdata);
        logic mis = v && (mr || mw) && m_mis(f3, a);
        logic mem = v && (mr || mw) && !mis;
        logic st = mw && !mr;
        exp_t e;
        in_valid_i = v; alu_result_i = a; store_data_i = sd; mem_read_i = mr; mem_write_i = mw;
        funct3_i = f3; reg_write_i = rw; rd_i = rd; dmem_ready_i = 1'b0;
        cap_stall = 0;
        if (!mem) begin
            @(negedge clk);
            chk("stall_nonmem", stall_o, 0);
            chk("req_nonmem", dmem_req_o, 0);
            @(posedge clk); #1;
            e = '{d: a, rw: v && rw && rd != 0 && !mis, rd: rd, cd: !mis, mis: mis};
            if (v) q.push_back(e);
        end else begin
            @(negedge clk);
            chk("stall_idle", stall_o, 1);
            chk("req_idle", dmem_req_o, 0);
            if (stall_o) cap_stall++;
            @(posedge clk); #1;
            for (int k = 1; k <= lat; k++) begin
                dmem_ready_i = (k == lat);
                dmem_rdata_i = (k == lat) ? rdata : 32'hDEAD_BEEF;
                @(negedge clk);
                chk("req_access", dmem_req_o, 1);
                chk("addr", dmem_addr_o, a & ~32'h3);
                chk("be", dmem_be_o, m_be(f3, a));
                chk("we", dmem_we_o, st);
                if (st) chk("wdata", dmem_wdata_o, m_wdata(f3, sd));
                chk("stall_access", stall_o, k != lat);
                if (stall_o) cap_stall++;
                cap_addr = dmem_addr_o; cap_be = dmem_be_o; cap_wdata = dmem_wdata_o; cap_we = dmem_we_o;
                @(posedge clk); #1;
            end
            dmem_ready_i = 1'b0;
            e = '{d: m_load(f3, a, rdata), rw: !st && rw && rd != 0, rd: rd, cd: !st, mis: 1'b0};
            q.push_back(e);
        end
        in_valid_i = 1'b0; mem_read_i = 1'b0; mem_write_i = 1'b0;
    endtask

    task automatic step;
        @(posedge clk); #1;
    endtask

    // Write-back compare: every cycle out of reset, wb_valid must match the model's pending entry.
    always @(negedge clk) begin
        if (reset) begin
            chk("wb_valid", wb_valid_o, q.size() > 0);
            if (wb_valid_o && q.size() > 0) begin
                ce = q.pop_front();
                if (ce.cd) chk("wb_data", wb_data_o, ce.d);
                chk("wb_reg_write", wb_reg_write_o, ce.rw);
                chk("wb_rd", wb_rd_o, ce.rd);
`ifdef MEM_MISALIGN_TRAP_EN
                chk("misalign", misalign_o, ce.mis);
            end else begin
                chk("misalign_idle", misalign_o, 0);
`endif
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; in_valid_i = 0; alu_result_i = 0; store_data_i = 0; mem_read_i = 0; mem_write_i = 0;
        funct3_i = 0; reg_write_i = 0; rd_i = 0; dmem_ready_i = 0; dmem_rdata_i = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", dmem_req_o, 0);
        chk("rst_we", dmem_we_o, 0);
        chk("rst_addr", dmem_addr_o, 0);
        chk("rst_be", dmem_be_o, 0);
        chk("rst_wdata", dmem_wdata_o, 0);
        chk("rst_wb_valid", wb_valid_o, 0);
        chk("rst_wb_data", wb_data_o, 0);
        chk("rst_wb_rw", wb_reg_write_o, 0);
        chk("rst_wb_rd", wb_rd_o, 0);
        reset = 1'b1;
        step();

        op(1, 32'h1234, 0, 0, 0, 3'd0, 1, 5'd5, 0, 0);
        @(negedge clk);
        chk("lit_alu_data", wb_data_o, 32'h1234);
        chk("lit_alu_rd", wb_rd_o, 5);
        chk("lit_alu_rw", wb_reg_write_o, 1);
        step();

        op(1, 32'h103, 0, 1, 0, 3'd0, 1, 5'd6, 4, 32'h80FF_0000);
        chk("lit_lb_addr", cap_addr, 32'h100);
        chk("lit_lb_be", cap_be, 4'b1000);
        chk("lit_lb_stall", cap_stall, 4);
        @(negedge clk);
        chk("lit_lb_data", wb_data_o, 32'hFFFF_FF80);
        step();

        op(1, 32'h102, 0, 1, 0, 3'd5, 1, 5'd7, 1, 32'hBEEF_0000);
        chk("lit_lhu_be", cap_be, 4'b1100);
        @(negedge clk);
        chk("lit_lhu_data", wb_data_o, 32'h0000_BEEF);
        chk("lit_lhu_rw", wb_reg_write_o, 1);
        step();

        op(1, 32'h201, 32'h0000_00AB, 0, 1, 3'd0, 1, 5'd8, 2, 0);
        chk("lit_sb_we", cap_we, 1);
        chk("lit_sb_be", cap_be, 4'b0010);
        chk("lit_sb_wdata", cap_wdata, 32'hABAB_ABAB);
        @(negedge clk);
        chk("lit_sb_rw", wb_reg_write_o, 0);
        step();

        // Back-to-back mixed traffic checked only by the model.
        op(1, 32'h106, 0, 1, 0, 3'd1, 1, 5'd9, 2, 32'h8001_1234);
        op(1, 32'h104, 0, 1, 0, 3'd2, 1, 5'd10, 1, 32'h1234_5678);
        op(1, 32'h302, 32'h1234_CDEF, 0, 1, 3'd1, 0, 5'd0, 1, 0);
        op(1, 32'h300, 32'hCAFE_F00D, 0, 1, 3'd2, 1, 5'd11, 3, 0);
        op(1, 32'h101, 0, 1, 0, 3'd4, 1, 5'd12, 1, 32'h0000_A500);
        op(1, 32'h200, 32'hFFFF_FFFF, 1, 1, 3'd2, 1, 5'd13, 1, 32'h1122_3344);
        op(1, 32'h208, 0, 1, 0, 3'd3, 1, 5'd14, 1, 32'h5566_7788);
        op(1, 32'h4321, 0, 0, 0, 3'd0, 1, 5'd0, 0, 0);
        op(0, 32'h500, 0, 1, 0, 3'd2, 1, 5'd15, 0, 0);
        op(1, 32'h102, 0, 1, 0, 3'd2, 1, 5'd16, 1, 32'h99AA_BBCC);
`ifdef MEM_MISALIGN_TRAP_EN
        @(negedge clk);
        chk("lit_mis_flag", misalign_o, 1);
        chk("lit_mis_rw", wb_reg_write_o, 0);
        chk("lit_mis_req", dmem_req_o, 0);
        step();
`else
        chk("lit_trunc_addr", cap_addr, 32'h100);
        chk("lit_trunc_be", cap_be, 4'hF);
        @(negedge clk);
        chk("lit_trunc_data", wb_data_o, 32'h99AA_BBCC);
        step();
`endif

        // Reset in the middle of an access abandons it.
        op(1, 32'h5555, 0, 0, 0, 3'd0, 1, 5'd7, 0, 0);
        in_valid_i = 1; alu_result_i = 32'h400; mem_read_i = 1; funct3_i = 3'd2; reg_write_i = 1; rd_i = 5'd3;
        step();
        @(negedge clk);
        chk("mid_req", dmem_req_o, 1);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_req", dmem_req_o, 0);
        chk("mid_rst_wb_valid", wb_valid_o, 0);
        chk("mid_rst_wb_data", wb_data_o, 0);
        chk("mid_rst_wb_rw", wb_reg_write_o, 0);
        chk("mid_rst_wb_rd", wb_rd_o, 0);
        in_valid_i = 0; mem_read_i = 0;
        step();
        reset = 1'b1;
        @(negedge clk);
        chk("post_rst_req", dmem_req_o, 0);
        chk("post_rst_stall", stall_o, 0);
        step();
        op(1, 32'h77, 0, 0, 0, 3'd0, 1, 5'd4, 0, 0);
        op(1, 32'h10, 0, 1, 0, 3'd2, 1, 5'd2, 1, 32'h0BAD_F00D);
        repeat (3) step();
        chk("model_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
